// File: rtl/instruction_fetch.sv
// Instruction fetch unit: program counter, instruction-memory address, and a one-entry output register to decode.
// Optional `FETCH_ZERO_HALT_EN: when defined, an all-zero instruction word marks end-of-program.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 1280
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] address,
   input  logic [31:0] instruction,
   output logic        fetch_valid,
   output logic [31:0] fetch_instr,
   output logic [31:0] fetch_pc,
   input  logic        fetch_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic        fault
);

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   localparam logic [31:0] LP_MEM_WORDS = MEM_WORDS;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_fetch_pc;
   logic        r_fault;

   logic [31:0] w_pc_word;
   logic [31:0] w_redirect_target;
   logic        w_out_of_range;
   logic        w_end_of_program;
   logic        w_slot_free;
   logic        w_consume;

   assign w_pc_word         = {2'b00, r_pc[31:2]};
   assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign w_out_of_range    = (w_pc_word >= LP_MEM_WORDS);
   assign w_slot_free       = !r_valid || fetch_ready;
   assign w_consume         = r_valid && fetch_ready;

`ifdef FETCH_ZERO_HALT_EN
   assign w_end_of_program = (instruction == 32'h0000_0000);
`else
   assign w_end_of_program = 1'b0;
`endif

   // Halt detection does not wait for a free output slot; a pending output is still drained in HALT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_valid    <= 1'b0;
         r_instr    <= 32'h0000_0000;
         r_fetch_pc <= 32'h0000_0000;
         r_fault    <= 1'b0;
      end else if (redirect_valid) begin
         r_state <= ST_RUN;
         r_pc    <= w_redirect_target;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         if (w_consume) begin
            r_valid <= 1'b0;
         end
         if (r_state == ST_RUN) begin
            if (w_out_of_range) begin
               r_state <= ST_HALT;
               r_fault <= 1'b1;
            end else if (w_end_of_program) begin
               r_state <= ST_HALT;
            end else if (w_slot_free) begin
               r_instr    <= instruction;
               r_fetch_pc <= r_pc;
               r_valid    <= 1'b1;
               r_pc       <= r_pc + 32'd4;
            end
         end
      end
   end

   assign address     = r_pc;
   assign fetch_valid = r_valid;
   assign fetch_instr = r_instr;
   assign fetch_pc    = r_fetch_pc;
   assign halted      = (r_state == ST_HALT);
   assign fault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a combinational instruction-memory model.
// Expectations adapt to whether FETCH_ZERO_HALT_EN is defined for the build.
`timescale 1ns/1ps
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] instruction;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        fault;

   int tests_run;
   int tests_failed;

   instruction_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .address        (address),
      .instruction    (instruction),
      .fetch_valid    (fetch_valid),
      .fetch_instr    (fetch_instr),
      .fetch_pc       (fetch_pc),
      .fetch_ready    (fetch_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Preloaded memory: nonzero words at indices 0..11, zero elsewhere.
   function automatic logic [31:0] mem_word(input int unsigned idx);
      if (idx < 12) return 32'hC0DE_0000 + idx * 32'h0000_0101 + 32'd1;
      return 32'h0000_0000;
   endfunction

   always_comb instruction = mem_word(int'(address[31:2]));

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end else begin
         $display("ok   %s: %h", tag, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc, input int unsigned idx);
      check_val({tag, " valid"}, {31'b0, fetch_valid}, 32'd1);
      check_val({tag, " pc"}, fetch_pc, pc);
      check_val({tag, " instr"}, fetch_instr, mem_word(idx));
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, " address"}, address, 32'h0);
      check_val({tag, " valid"}, {31'b0, fetch_valid}, 32'd0);
      check_val({tag, " instr"}, fetch_instr, 32'h0);
      check_val({tag, " pc"}, fetch_pc, 32'h0);
      check_val({tag, " halted"}, {31'b0, halted}, 32'd0);
      check_val({tag, " fault"}, {31'b0, fault}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst_n          = 1'b0;
      fetch_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      #3;
      check_reset_state("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Free run from reset
      for (int k = 0; k < 12; k++) begin
         tick();
         check_out($sformatf("run%0d", k), 32'(k * 4), k);
      end
      check_val("run addr", address, 32'h30);
      tick();
`ifdef FETCH_ZERO_HALT_EN
      check_val("eop halted", {31'b0, halted}, 32'd1);
      check_val("eop fault", {31'b0, fault}, 32'd0);
      check_val("eop address", address, 32'h30);
      check_val("eop valid", {31'b0, fetch_valid}, 32'd0);
      tick();
      check_val("eop hold addr", address, 32'h30);
      check_val("eop hold valid", {31'b0, fetch_valid}, 32'd0);
`else
      check_out("zero word", 32'h30, 12);
      check_val("zero halted", {31'b0, halted}, 32'd0);
`endif

      // Redirect (from HALT when end-of-program is enabled)
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1A;
      tick();
      redirect_valid = 1'b0;
      check_val("redir address", address, 32'h18);
      check_val("redir halted", {31'b0, halted}, 32'd0);
      check_val("redir valid", {31'b0, fetch_valid}, 32'd0);
      tick();
      check_out("redir target", 32'h18, 6);

      // Backpressure at fetch_pc = 0x08
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      tick();
      redirect_valid = 1'b0;
      tick();
      check_out("bp w0", 32'h00, 0);
      tick();
      check_out("bp w1", 32'h04, 1);
      tick();
      check_out("bp w2", 32'h08, 2);
      fetch_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_out($sformatf("bp hold%0d", k), 32'h08, 2);
         check_val($sformatf("bp hold%0d addr", k), address, 32'h0C);
      end
      fetch_ready = 1'b1;
      tick();
      check_out("bp rel0", 32'h0C, 3);
      tick();
      check_out("bp rel1", 32'h10, 4);

      // Redirect with simultaneous consume of 0x10
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      tick();
      redirect_valid = 1'b0;
      check_val("rc valid", {31'b0, fetch_valid}, 32'd0);
      check_val("rc address", address, 32'h0);
      tick();
      check_out("rc next", 32'h00, 0);

      // Run up to 0x14, then reset mid-run
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_out($sformatf("pre%0d", k), 32'(k * 4), k);
      end
      rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      #1;
      rst_n = 1'b1;
      tick();
      check_out("restart", 32'h00, 0);
      check_val("restart addr", address, 32'h04);

      // Out-of-range redirect target, then recovery
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1400;
      tick();
      redirect_valid = 1'b0;
      check_val("oor address", address, 32'h1400);
      check_val("oor valid0", {31'b0, fetch_valid}, 32'd0);
      tick();
      check_val("oor halted", {31'b0, halted}, 32'd1);
      check_val("oor fault", {31'b0, fault}, 32'd1);
      check_val("oor valid1", {31'b0, fetch_valid}, 32'd0);
      check_val("oor hold addr", address, 32'h1400);
      tick();
      check_val("oor valid2", {31'b0, fetch_valid}, 32'd0);
      check_val("oor still fault", {31'b0, fault}, 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      tick();
      redirect_valid = 1'b0;
      check_val("clr fault", {31'b0, fault}, 32'd0);
      check_val("clr halted", {31'b0, halted}, 32'd0);
      check_val("clr address", address, 32'h0);
      tick();
      check_out("clr fetch", 32'h00, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit, the initiator side of the instruction memory's address/instruction interface. It owns the program counter, drives the word-aligned byte address into the instruction memory, and captures the combinationally returned word into a one-entry output register. That register feeds decode through a valid/ready handshake. It also handles branch/jump redirects and stops fetching at end-of-program or on an out-of-range address.

## Interface
- `RESET_PC`, default 0: byte address fetched first after reset; bits [1:0] must be 0.
- `MEM_WORDS`, default 1280: instruction memory depth in 32-bit words; sets the legal address range.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `address` output, 32: byte address to instruction memory; always equals the internal PC.
- `instruction` input, 32: word returned combinationally by instruction memory for `address`.
- `fetch_valid` output, 1: output register holds a valid instruction.
- `fetch_instr` output, 32: captured instruction.
- `fetch_pc` output, 32: byte address of `fetch_instr`.
- `fetch_ready` input, 1: decode accepts the output this cycle.
- `redirect_valid` input, 1: load a new PC this cycle.
- `redirect_pc` input, 32: redirect target; bits [1:0] are forced to 0.
- `halted` output, 1: fetch is stopped.
- `fault` output, 1: the stop was caused by an out-of-range address.

## Operation
- States: RUN and HALT. `halted` is 1 exactly in HALT.
- Capture condition, evaluated in RUN: `!fetch_valid || fetch_ready`, and `redirect_valid` is 0.
- On capture:
  - `fetch_instr` <= `instruction`, `fetch_pc` <= PC, `fetch_valid` <= 1.
  - PC <= PC + 4, with 32-bit wrap.
- Consume without capture: a handshake (`fetch_valid && fetch_ready`) with no capture sets `fetch_valid` <= 0.
- Range check, before capture: if (PC >> 2) >= `MEM_WORDS`, there is no capture. The block goes to HALT, sets `fault` <= 1 and holds PC.
- End-of-program (only with the macro, see Configuration): if `instruction` == 0, there is no capture. The block goes to HALT with `fault` = 0 and holds PC.
- Redirect, from either state:
  - PC <= {`redirect_pc`[31:2], 2'b00}, `fetch_valid` <= 0. The current `instruction` is discarded.
  - State <= RUN, `fault` <= 0.
  - Redirect takes priority over capture, handshake, halt and fault.
- In HALT:
  - PC holds.
  - An already-valid output is still drained by `fetch_ready`.
  - Nothing new is captured.
- Simultaneous halt detection and consume: the held output is consumed (`fetch_valid` <= 0) and HALT is entered on the same edge.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - PC = `address` = `RESET_PC`
  - `fetch_valid` = 0, `fetch_instr` = 0, `fetch_pc` = 0
  - state RUN, `halted` = 0, `fault` = 0
- Fetch latency: the word at PC appears on `fetch_*` one cycle after PC is driven on `address`.
- Throughput: one instruction per cycle while `fetch_ready` = 1.
- Backpressure: while `fetch_valid && !fetch_ready`, all `fetch_*` outputs and PC hold stable. No word is skipped or duplicated.
- Redirect latency: on the edge where `redirect_valid` is sampled, `address` = target and `fetch_valid` = 0. The target instruction is valid after the next edge, so redirect to valid is 2 edges.
- `halted` and `fault` change on the edge where the condition is sampled.
- Reset mid-operation discards any held instruction and in-flight PC immediately.

## Configuration
- `FETCH_ZERO_HALT_EN` defined: an all-zero instruction word is the end-of-program marker. It is not captured, and the block enters HALT with `fault` = 0.
- `FETCH_ZERO_HALT_EN` undefined: a zero word is captured and passed to decode like any other instruction. HALT is reached only through the range check.

## Test plan
Memory is preloaded with nonzero words at indices 0–11 and zero from index 12 upward.
- Free-run, macro defined, `fetch_ready` = 1 from reset:
  - `fetch_pc` = 0x00, 0x04, …, 0x2C on 12 consecutive cycles, each `fetch_instr` matching its memory word.
  - `halted` = 1 with `fault` = 0 while `address` = 0x30, and `fetch_valid` falls after 0x2C is consumed.
- Backpressure: drop `fetch_ready` for 3 cycles while `fetch_pc` = 0x08:
  - `fetch_instr` = word 2 and `fetch_pc` = 0x08 hold throughout, `address` holds at 0x0C.
  - On release, the next outputs are 0x0C then 0x10.
- Redirect while halted: `redirect_pc` = 0x1A:
  - Next cycle `address` = 0x18, `halted` = 0, `fetch_valid` = 0.
  - One cycle later `fetch_pc` = 0x18 with word 6.
- Redirect with simultaneous consume, at `fetch_pc` = 0x10, `redirect_pc` = 0x00: 0x10 is consumed, 0x14 is never presented, and the next valid output is `fetch_pc` = 0x00.
- Out-of-range, macro undefined: `redirect_pc` = 0x1400 (word 1280) gives `halted` = 1, `fault` = 1 and no capture. A later `redirect_pc` = 0x00 clears `fault`.
- Reset mid-run: assert `rst_n` = 0 while `fetch_valid` = 1 and `fetch_pc` = 0x14. All outputs take their reset values immediately, and after release fetch restarts at `RESET_PC`.
